rv_wb_stage: RTL

Writeback stage for the 64-bit RISC-V core. Accepts results from the single-cycle ALU and from the load unit, arbitrates them into one registered write per cycle, and drives the register file write port (`writeR`, `write_data`, `write`). Also keeps the destination-register scoreboard (`busy`) that decode uses to stall on read-after-write hazards against in-flight results.

---
 rtl/rv_wb_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/rv_wb_stage.sv
// Writeback stage: merges ALU and load results into one registered register-file
// write per cycle, and tracks in-flight destinations in the busy scoreboard.
module rv_wb_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            ld_valid,
   input  logic [4:0]      ld_rd,
   input  logic [XLEN-1:0] ld_data,
   output logic            ld_ready,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rd,
   output logic [4:0]      writeR,
   output logic [XLEN-1:0] write_data,
   output logic            write,
   output logic [31:0]     busy
);

   // Handshake: a source transfers on a rising edge where valid && ready are both
   // high; valid/rd/data stay stable until then, and ready never depends on valid.
   logic            hold_full;
   logic [4:0]      hold_rd;
   logic [XLEN-1:0] hold_data;

   logic            sel_valid;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic            capture_hold;
   logic            sel_writes;
   logic [31:0]     busy_next;

   always_comb begin
      alu_ready = !rst && !hold_full;
      ld_ready  = !rst && !hold_full;
   end

   // Oldest first: a held ALU result beats new inputs, and a load beats a same-cycle ALU.
   always_comb begin
      sel_valid    = 1'b0;
      sel_rd       = hold_rd;
      sel_data     = hold_data;
      capture_hold = 1'b0;
      if (hold_full) begin
         sel_valid = 1'b1;
      end else if (ld_valid) begin
         sel_valid    = 1'b1;
         sel_rd       = ld_rd;
         sel_data     = ld_data;
         capture_hold = alu_valid;
      end else if (alu_valid) begin
         sel_valid = 1'b1;
         sel_rd    = alu_rd;
         sel_data  = alu_data;
      end
   end

   assign sel_writes = sel_valid && (sel_rd != 5'd0);

   // A new issue to the same register is the newer producer, so its set wins over the clear.
   always_comb begin
      busy_next = busy;
      if (write) busy_next[writeR] = 1'b0;
      if (iss_valid && (iss_rd != 5'd0)) busy_next[iss_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         write      <= 1'b0;
         writeR     <= 5'd0;
         write_data <= '0;
         hold_full  <= 1'b0;
         hold_rd    <= 5'd0;
         hold_data  <= '0;
         busy       <= 32'd0;
      end else begin
         write     <= sel_writes;
         hold_full <= capture_hold;
         busy      <= busy_next;
         if (sel_writes) begin
            writeR     <= sel_rd;
            write_data <= sel_data;
         end
         if (capture_hold) begin
            hold_rd   <= alu_rd;
            hold_data <= alu_data;
         end
      end
   end

endmodule
